dcm_reader: RTL

- Controller and consumer side of the DCM request/ready/finish handshake.
- On `start` it runs two measurements:
  - `pos_neg`=0: high-phase pulse width.
  - `pos_neg`=1: low-phase pulse width.
- For each measurement it issues `request`, waits for `ready`, captures a settled `theta` thermometer word, converts it to binary and releases the DCM with `finish`.
- It reports both codes and their signed difference (duty error) for the DCC loop.

---
 rtl/dcm_reader.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dcm_reader.sv
// DCM reader: drives the request/ready/finish handshake for both clock phases and reports codes plus duty error.
// Latency: about 2*(REQ + 2 sync + SETTLE + capture + FIN + 2 sync) + 1 cycles from start to done with a prompt DCM.
// Backpressure: each wait state stalls on the synchronized DCM ready; TIMEOUT cycles in one wait aborts the run.
module dcm_reader #(
  parameter int LEVEL   = 20,
  parameter int CW      = 5,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_in,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              request,
  input  logic              ready,
  output logic              finish,
  output logic              pos_neg,
  input  logic [LEVEL-1:0]  theta,
  output logic [CW-1:0]     code_pos,
  output logic [CW-1:0]     code_neg,
  output logic [CW:0]       duty_err,
  output logic              done,
  output logic              bubble_err,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_FIN     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // The wait counter is shared by every wait state; SETTLE reuses it as its cycle count.
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic               pos_neg_q, pos_neg_d;
  logic               request_q, request_d;
  logic               finish_q, finish_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               bubble_err_q, bubble_err_d;
  logic               timeout_q, timeout_d;
  logic [CW-1:0]      code_pos_q, code_pos_d;
  logic [CW-1:0]      code_neg_q, code_neg_d;
  logic [CW:0]        duty_err_q, duty_err_d;
  logic [7:0]         cnt_q, cnt_d;

  // Two-flop synchronizers; theta_p keeps the previous synchronized word for the stability compare.
  logic               ready_s1_q, ready_s_q;
  logic [LEVEL-1:0]   theta_s1_q, theta_s_q, theta_p_q;

  logic               theta_stable;
  logic [CW-1:0]      theta_code;
  logic [LEVEL-1:0]   theta_inc;
  logic               theta_bubble;
  logic               abort;

  // Ones count of the thermometer word; a bubbled word still reports its ones count.
  function automatic logic [CW-1:0] popcount(input logic [LEVEL-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < LEVEL; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // A multi-bit word crossing asynchronously can tear, so capture only when two samples agree.
  always_comb begin
    theta_stable = (theta_s_q == theta_p_q);
    theta_code   = popcount(theta_s_q);
    theta_inc    = theta_s_q + LEVEL'(1);
    theta_bubble = ((theta_s_q & theta_inc) != '0);
  end

  // Next-state, result and handshake logic; abort overrides whatever the wait state chose.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pos_neg_d    = pos_neg_q;
    code_pos_d   = code_pos_q;
    code_neg_d   = code_neg_q;
    duty_err_d   = duty_err_q;
    bubble_err_d = bubble_err_q;
    timeout_d    = timeout_q;
    done_d       = 1'b0;
    abort        = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bubble_err_d = 1'b0;
          timeout_d    = 1'b0;
          pos_neg_d    = 1'b0;
          phase_d      = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (ready_s_q) begin
          state_d = S_SETTLE;
        end else if (cnt_q == TMO_LAST) begin
          abort = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
        end else if (cnt_q == TMO_LAST) begin
          abort = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (theta_stable) begin
          if (theta_bubble) begin
            bubble_err_d = 1'b1;
          end
          if (!phase_q) begin
            code_pos_d = theta_code;
          end else begin
            code_neg_d = theta_code;
          end
          state_d = S_FIN;
        end else if (cnt_q == TMO_LAST) begin
          abort = 1'b1;
        end
      end
      S_FIN: begin
        if (!ready_s_q) begin
          if (!phase_q) begin
            // finish drops on this edge and request only rises one cycle later,
            // so the phase select moves while both handshake lines are low.
            phase_d   = 1'b1;
            pos_neg_d = 1'b1;
            state_d   = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_q == TMO_LAST) begin
          abort = 1'b1;
        end
      end
      S_DONE: begin
        // Codes are unsigned magnitudes, so widen with a zero before subtracting.
        duty_err_d = {1'b0, code_pos_q} - {1'b0, code_neg_q};
        done_d     = 1'b1;
        pos_neg_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      timeout_d = 1'b1;
      done_d    = 1'b1;
      pos_neg_d = 1'b0;
      state_d   = S_IDLE;
    end

    // SETTLE and CAPTURE share one timeout window, so that transition keeps counting.
    if ((state_d != state_q) && !((state_q == S_SETTLE) && (state_d == S_CAPTURE))) begin
      cnt_d = '0;
    end else if (state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = cnt_q + 8'd1;
    end

    // request rises one cycle after entering REQ, leaving a quiet cycle after a phase change.
    request_d = (state_q == S_REQ) && (state_d == S_REQ);
    finish_d  = (state_d == S_FIN);
    busy_d    = (state_d != S_IDLE);
  end

  // State, result and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      pos_neg_q    <= 1'b0;
      request_q    <= 1'b0;
      finish_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bubble_err_q <= 1'b0;
      timeout_q    <= 1'b0;
      code_pos_q   <= '0;
      code_neg_q   <= '0;
      duty_err_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pos_neg_q    <= pos_neg_d;
      request_q    <= request_d;
      finish_q     <= finish_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      bubble_err_q <= bubble_err_d;
      timeout_q    <= timeout_d;
      code_pos_q   <= code_pos_d;
      code_neg_q   <= code_neg_d;
      duty_err_q   <= duty_err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Synchronizer chains for the asynchronous DCM inputs.
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      ready_s1_q <= 1'b0;
      ready_s_q  <= 1'b0;
      theta_s1_q <= '0;
      theta_s_q  <= '0;
      theta_p_q  <= '0;
    end else begin
      ready_s1_q <= ready;
      ready_s_q  <= ready_s1_q;
      theta_s1_q <= theta;
      theta_s_q  <= theta_s1_q;
      theta_p_q  <= theta_s_q;
    end
  end

  assign busy       = busy_q;
  assign request    = request_q;
  assign finish     = finish_q;
  assign pos_neg    = pos_neg_q;
  assign done       = done_q;
  assign bubble_err = bubble_err_q;
  assign timeout    = timeout_q;
  assign code_pos   = code_pos_q;
  assign code_neg   = code_neg_q;
  assign duty_err   = duty_err_q;

endmodule
